// File: rtl/regfile_mp_sb_pkg.sv
// Shared core definitions for the multi-port register file and its hazard scoreboard.
// Decode and hazard units import the same defaults so their widths agree.
package regfile_mp_sb_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_t;

  localparam int REG_ZERO      = 0;
  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 32;

endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Per-register busy scoreboard: a write commit clears, a reserve sets.
// A reserve wins over a same-cycle commit to the same register.
module regfile_sb_scoreboard
  import regfile_mp_sb_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int NUM_RD = 2,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 wr_en,
  input  logic [AW-1:0]        wr_addr,
  input  logic                 rsv_en,
  input  logic [AW-1:0]        rsv_addr,
  input  logic [NUM_RD*AW-1:0] rd_addr,
  output logic [NUM_RD-1:0]    rd_busy
);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  // The set is applied after the clear so a new producer wins the tie.
  always_comb begin
    busy_d = busy_q;
    if (run) begin
      if (wr_en && (wr_addr != AW'(REG_ZERO))) begin
        busy_d[wr_addr] = 1'b0;
      end
      if (rsv_en && (rsv_addr != AW'(REG_ZERO))) begin
        busy_d[rsv_addr] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Lookups see registered state only; a same-cycle commit does not hide busy.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_lookup
    logic [AW-1:0] addr_k;
    assign addr_k     = rd_addr[k*AW +: AW];
    assign rd_busy[k] = run && busy_q[addr_k];
  end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-read-port register file with hardwired r0, write-first bypass,
// busy scoreboard and a sequenced post-reset clear that raises ready.
module regfile_mp_sb
  import regfile_mp_sb_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int NUM_RD = 2,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_RD*AW-1:0]    rd_addr,
  output logic [NUM_RD*WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]       rd_busy,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic                    rsv_en,
  input  logic [AW-1:0]           rsv_addr,
  output logic                    ready
);

  rf_state_t        state_q;
  rf_state_t        state_d;
  logic [AW-1:0]    clr_cnt_q;
  logic [AW-1:0]    clr_cnt_d;
  logic             run;
  logic             wr_commit;
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // The counter walks every entry once; the wrap on the last entry hands over to RUN.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      CLEAR: begin
        clr_cnt_d = clr_cnt_q + AW'(1);
        if (clr_cnt_q == AW'(DEPTH - 1)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = CLEAR;
      end
    endcase
  end

  assign run       = (state_q == RUN);
  assign ready     = run;
  assign wr_commit = run && wr_en && (wr_addr != AW'(REG_ZERO));

  // A reset in the same cycle abandons whatever write was in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (!run) begin
        mem[clr_cnt_q] <= '0;
      end else if (wr_commit) begin
        mem[wr_addr] <= wr_data;
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_read
    logic [AW-1:0] addr_k;
    assign addr_k = rd_addr[k*AW +: AW];
    always_comb begin
      rd_data[k*WIDTH +: WIDTH] = '0;
      if (run && (addr_k != AW'(REG_ZERO))) begin
        if (wr_commit && (wr_addr == addr_k)) begin
          rd_data[k*WIDTH +: WIDTH] = wr_data;
        end else begin
          rd_data[k*WIDTH +: WIDTH] = mem[addr_k];
        end
      end
    end
  end

  regfile_sb_scoreboard #(
    .DEPTH  (DEPTH),
    .NUM_RD (NUM_RD)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .rd_addr  (rd_addr),
    .rd_busy  (rd_busy)
  );

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench for regfile_mp_sb: default 32x32/2-port instance plus a 16x8/3-port instance.
module tb_regfile_mp_sb;

  logic        clk = 1'b0;
  logic        rst;

  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic        ready;

  logic [8:0]  s_rd_addr;
  logic [47:0] s_rd_data;
  logic [2:0]  s_rd_busy;
  logic        s_wr_en;
  logic [2:0]  s_wr_addr;
  logic [15:0] s_wr_data;
  logic        s_rsv_en;
  logic [2:0]  s_rsv_addr;
  logic        s_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_mp_sb dut (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .ready    (ready)
  );

  regfile_mp_sb #(
    .WIDTH  (16),
    .DEPTH  (8),
    .NUM_RD (3)
  ) dut_small (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (s_rd_addr),
    .rd_data  (s_rd_data),
    .rd_busy  (s_rd_busy),
    .wr_en    (s_wr_en),
    .wr_addr  (s_wr_addr),
    .wr_data  (s_wr_data),
    .rsv_en   (s_rsv_en),
    .rsv_addr (s_rsv_addr),
    .ready    (s_ready)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                               input logic re, input logic [4:0] ra);
    wr_en    = we;
    wr_addr  = wa;
    wr_data  = wd;
    rsv_en   = re;
    rsv_addr = ra;
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    rd_addr    = '0;
    s_rd_addr  = '0;
    s_wr_en    = 1'b0;
    s_wr_addr  = '0;
    s_wr_data  = '0;
    s_rsv_en   = 1'b0;
    s_rsv_addr = '0;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("reset_ready", 64'(ready), 64'd0);
    checkOutput("reset_small_ready", 64'(s_ready), 64'd0);

    // Traffic during CLEAR must be ignored and reads must stay zero.
    applyStimulus(1'b1, 5'd5, 32'hDEAD, 1'b1, 5'd6);
    rd_addr = {5'd6, 5'd5};
    #1;
    checkOutput("clear_rd_zero", 64'(rd_data), 64'd0);
    checkOutput("clear_busy_zero", 64'(rd_busy), 64'd0);
    for (int i = 1; i <= 32; i++) begin
      step();
      if (i == 3) applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      if (i == 7)  checkOutput("small_ready_7", 64'(s_ready), 64'd0);
      if (i == 8)  checkOutput("small_ready_8", 64'(s_ready), 64'd1);
      if (i == 31) checkOutput("ready_31", 64'(ready), 64'd0);
      if (i == 32) checkOutput("ready_32", 64'(ready), 64'd1);
    end

    for (int a = 0; a < 32; a++) begin
      rd_addr = {5'(31 - a), 5'(a)};
      #1;
      checkOutput($sformatf("cleared_r%0d", a), 64'(rd_data[31:0]), 64'd0);
    end
    rd_addr = {5'd6, 5'd5};
    #1;
    checkOutput("clear_wr_ignored_r5", 64'(rd_data[31:0]), 64'd0);
    checkOutput("clear_rsv_ignored_r6", 64'(rd_busy[1]), 64'd0);

    applyStimulus(1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0);
    step();
    applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0);
    rd_addr = {5'd7, 5'd0};
    #1;
    checkOutput("r0_bypass_blocked", 64'(rd_data[31:0]), 64'd0);
    checkOutput("r7_read_p1", 64'(rd_data[63:32]), 64'hA5A5A5A5);
    step();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    rd_addr = {5'd7, 5'd7};
    #1;
    checkOutput("r7_read_both", 64'(rd_data), {32'hA5A5A5A5, 32'hA5A5A5A5});
    rd_addr = {5'd7, 5'd0};
    #1;
    checkOutput("r0_after_write", 64'(rd_data[31:0]), 64'd0);

    applyStimulus(1'b1, 5'd3, 32'h12345678, 1'b0, 5'd0);
    rd_addr = {5'd3, 5'd3};
    #1;
    checkOutput("bypass_r3_both", 64'(rd_data), {32'h12345678, 32'h12345678});
    step();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    #1;
    checkOutput("r3_stored", 64'(rd_data[31:0]), 64'h12345678);

    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9);
    rd_addr = {5'd0, 5'd9};
    #1;
    checkOutput("rsv_not_yet_busy", 64'(rd_busy[0]), 64'd0);
    step();
    applyStimulus(1'b1, 5'd9, 32'h99, 1'b0, 5'd0);
    #1;
    checkOutput("r9_busy", 64'(rd_busy[0]), 64'd1);
    checkOutput("r9_bypass_while_busy", 64'(rd_data[31:0]), 64'h99);
    step();
    applyStimulus(1'b1, 5'd9, 32'h9A, 1'b1, 5'd9);
    #1;
    checkOutput("r9_cleared", 64'(rd_busy[0]), 64'd0);
    step();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0);
    #1;
    checkOutput("r9_rsv_wins", 64'(rd_busy[0]), 64'd1);
    step();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    rd_addr = {5'd0, 5'd9};
    #1;
    checkOutput("r0_never_busy", 64'(rd_busy[1]), 64'd0);
    checkOutput("r9_still_busy", 64'(rd_busy[0]), 64'd1);

    // Three-port instance: ports 0 and 2 read r1 during a write, port 1 reads stored r2.
    s_wr_en   = 1'b1;
    s_wr_addr = 3'd2;
    s_wr_data = 16'h1234;
    step();
    s_wr_addr = 3'd1;
    s_wr_data = 16'hBEEF;
    s_rd_addr = {3'd1, 3'd2, 3'd1};
    #1;
    checkOutput("small_three_ports", 64'(s_rd_data), 64'({16'hBEEF, 16'h1234, 16'hBEEF}));
    step();
    s_wr_en = 1'b0;

    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd4);
    step();
    applyStimulus(1'b1, 5'd4, 32'h55, 1'b1, 5'd10);
    step();
    applyStimulus(1'b1, 5'd4, 32'h77, 1'b0, 5'd0);
    rd_addr = {5'd10, 5'd4};
    #1;
    checkOutput("r10_busy_before_rst", 64'(rd_busy[1]), 64'd1);
    rst = 1'b1;
    step();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
    #1;
    checkOutput("midrst_ready_low", 64'(ready), 64'd0);
    checkOutput("midrst_busy_zero", 64'(rd_busy), 64'd0);
    rst = 1'b0;
    for (int n = 0; n < 100 && !ready; n++) step();
    checkOutput("midrst_ready_back", 64'(ready), 64'd1);
    rd_addr = {5'd10, 5'd4};
    #1;
    checkOutput("midrst_r4_zero", 64'(rd_data[31:0]), 64'd0);
    checkOutput("midrst_r10_not_busy", 64'(rd_busy[1]), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
